rnn_mem_responder: RTL and testbench
====================================

Name: rnn_mem_responder

Overview:
- Memory-side and stimulus-side counterpart of the RNN accelerator core.
- Answers the core's `mce`/`msel`/`maddr` requests. Read data (weights, biases, sequence length) returns with 1-cycle latency; writes of hidden-state results are stored.
- Drives the `ready`/`idata` input handshake, one 32-bit x vector per `i_en`.
- A host load/readback port preloads weights and inputs and reads back results. Used as the integration harness and as the on-chip memory wrapper.

Parameters:
- T_MAX, 32, max sequence length; x memory depth and H depth = T_MAX*64.
- DW, 20, memory data width (fixed Q4.16 signed words).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mce  in  1  memory request enable from core
- msel  in  3  region select
- maddr  in  17  region word address
- mdata_w  in  20  write data from core
- mdata_r  out  20  registered read data
- ready  out  1  input offer to core
- busy  in  1  core busy
- i_en  in  1  core requests next x vector
- idata  out  32  x vector, 1 bit per input
- start  in  1  host pulse: begin a run
- seq_len  in  11  host-set sequence length, sampled on start
- ld_en  in  1  host write strobe
- ld_sel  in  3  host region (000, 001, 010, 011 weights/biases; 110 = X)
- ld_addr  in  12  host address
- ld_data  in  32  host data (low 20 bits for weight regions)
- rd_addr  in  17  host H readback address
- rd_data  out  20  H[rd_addr], registered, 1-cycle latency
- done  out  1  1-cycle pulse at end of run
- wr_count  out  17  H writes since start
- err  out  1  sticky protocol/range error

Behaviour:
- Reset values: mdata_r=0, idata=0, ready=0, done=0, rd_data=0, wr_count=0, err=0, xptr=0, FSM=IDLE. Array contents are not cleared.

Region decode, when mce=1:
- 000 W_ih: index maddr[10:0], 2048 words.
- 001 b_ih: index maddr[5:0].
- 010 W_hh: index maddr[11:0], 4096 words.
- 011 b_hh: index maddr[5:0].
- 100: returns the latched seq_len, zero-extended.
- 101: write. H[maddr] <= mdata_w; wr_count++; mdata_r <= 0 that cycle.
- 110/111: mdata_r <= 0 and err set.

Read and address rules:
- Read latency is exactly 1: mdata_r at edge N+1 reflects the request at edge N. When mce=0, mdata_r holds its value.
- An H write with maddr >= T_MAX*64 is dropped and sets err.
- Region 000/010 addresses beyond the upper bits listed above are ignored (modulo region size), with no error.

Host port:
- ld_en writes the selected array at ld_addr. ld_sel=101 or 100 is ignored and sets err.
- Same-cycle host write and core read of the same word: the read returns old data.
- rd_data is always registered from H[rd_addr].

Handshake FSM (IDLE, OFFER, RUN, DONE):
- IDLE: on start, latch seq_len, xptr<=0, wr_count<=0, then go to OFFER. start in any other state is ignored.
- OFFER: ready=1. When busy=1 is sampled, go to RUN with ready<=0 on the same edge.
- RUN: when busy=0 is sampled, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- i_en=1 at edge N (any state): idata <= X[xptr] at edge N, valid from cycle N+1 until the next i_en; xptr++.
- The core issues seq_len+1 i_en pulses; the extra read returns X[seq_len] and is not an error.
- i_en with xptr=T_MAX: idata <= 0, err set, xptr holds.
- Reset mid-run: FSM to IDLE, ready=0, no done pulse. Memories keep their contents.

Decomposition:
- Package rnn_mem_pkg holds:
  - msel encodings: MSEL_WIH=000, MSEL_BIH=001, MSEL_WHH=010, MSEL_BHH=011, MSEL_LEN=100, MSEL_HOUT=101.
  - LD_X=110.
  - Region depths: WIH_DEPTH=2048, WHH_DEPTH=4096, B_DEPTH=64.
  - FSM state enum.
- Sub-module rnn_input_feeder contains the handshake FSM, the X array, xptr and idata. The top level holds the weight/bias/H arrays and the decode logic.

Test Plan:
1. Host loads W_ih[5]=20'h0ABCD. Core issues mce=1, msel=000, maddr=5 at edge N. Required: mdata_r=20'h0ABCD at N+1. Then mce=0 for 3 cycles: mdata_r stays 20'h0ABCD.
2. seq_len=7 and start. Required: ready=1 the next cycle. Core raises busy; ready drops the cycle after. Region 100 read returns 20'h00007.
3. X[0]=32'hDEADBEEF, X[1]=32'h00000001. Two i_en pulses 4 cycles apart. Required: idata=DEADBEEF, then 00000001, each valid from the cycle after its i_en.
4. Core writes msel=101 at maddr={11'd2,6'd63} with data 20'hF0000. Required: rd_addr=191 gives rd_data=20'hF0000; wr_count=1.
5. msel=110 read, H write at maddr=2048 (T_MAX=32), and i_en after 33 pulses. Required: err set after the first event and remaining set. H[2048] is not written and wr_count does not increment on the dropped write.
6. Reset asserted in RUN. Required: the next cycle has ready=0, done=0, FSM=IDLE. W_ih[5] still reads 20'h0ABCD. busy then falls: no done pulse.

Source files
------------

// File: rtl/rnn_mem_pkg.sv
// Shared encodings for the RNN memory responder: region selects, depths and
// the input-handshake state type.
package rnn_mem_pkg;

    localparam logic [2:0] MSEL_WIH  = 3'b000;
    localparam logic [2:0] MSEL_BIH  = 3'b001;
    localparam logic [2:0] MSEL_WHH  = 3'b010;
    localparam logic [2:0] MSEL_BHH  = 3'b011;
    localparam logic [2:0] MSEL_LEN  = 3'b100;
    localparam logic [2:0] MSEL_HOUT = 3'b101;
    localparam logic [2:0] LD_X      = 3'b110;

    localparam int WIH_DEPTH = 2048;
    localparam int WHH_DEPTH = 4096;
    localparam int B_DEPTH   = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_RUN,
        ST_DONE
    } feed_state_t;

endpackage

// File: rtl/rnn_input_feeder.sv
// Input-side handshake for the RNN core: offers a run, tracks busy, and
// streams one x vector per i_en from the host-loaded X array.
module rnn_input_feeder
    import rnn_mem_pkg::*;
#(
    parameter int T_MAX = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic [10:0]                    seq_len_i,
    input  logic                           busy_i,
    input  logic                           i_en_i,
    input  logic                           x_we_i,
    input  logic [$clog2(T_MAX*64)-1:0]    x_addr_i,
    input  logic [31:0]                    x_data_i,
    output logic                           ready_o,
    output logic                           done_o,
    output logic [31:0]                    idata_o,
    output logic [10:0]                    len_o,
    output logic                           run_start_o,
    output logic                           feed_err_o
);

    localparam int XAW = $clog2(T_MAX*64);
    localparam int XPW = $clog2(T_MAX+1);
    localparam logic [XPW-1:0] XP_MAX = XPW'(T_MAX);

    logic [31:0]    x_mem [T_MAX*64];
    feed_state_t    state_q;
    logic           ready_q;
    logic           done_q;
    logic [31:0]    idata_q;
    logic [XPW-1:0] xptr_q;
    logic [10:0]    len_q;

    always_ff @(posedge clk) begin
        if (x_we_i) begin
            x_mem[x_addr_i] <= x_data_i;
        end
    end

    // A start that lands together with i_en leaves xptr at zero for the new run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            idata_q <= '0;
            xptr_q  <= '0;
            len_q   <= '0;
        end else begin
            if (i_en_i) begin
                if (xptr_q != XP_MAX) begin
                    idata_q <= x_mem[XAW'(xptr_q)];
                    xptr_q  <= xptr_q + 1'b1;
                end else begin
                    idata_q <= '0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q   <= seq_len_i;
                        xptr_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (busy_i) begin
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!busy_i) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign idata_o     = idata_q;
    assign len_o       = len_q;
    assign run_start_o = (state_q == ST_IDLE) && start_i;
    assign feed_err_o  = i_en_i && (xptr_q == XP_MAX);

endmodule

// File: rtl/rnn_mem_responder.sv
// On-chip memory wrapper for the RNN core: weight/bias/H arrays with a
// 1-cycle read port, host load/readback, and the input feeder.
module rnn_mem_responder
    import rnn_mem_pkg::*;
#(
    parameter int T_MAX = 32,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mce,
    input  logic [2:0]    msel,
    input  logic [16:0]   maddr,
    input  logic [DW-1:0] mdata_w,
    output logic [DW-1:0] mdata_r,
    output logic          ready,
    input  logic          busy,
    input  logic          i_en,
    output logic [31:0]   idata,
    input  logic          start,
    input  logic [10:0]   seq_len,
    input  logic          ld_en,
    input  logic [2:0]    ld_sel,
    input  logic [11:0]   ld_addr,
    input  logic [31:0]   ld_data,
    input  logic [16:0]   rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic [16:0]   wr_count,
    output logic          err
);

    localparam int HD  = T_MAX*64;
    localparam int HAW = $clog2(HD);
    localparam logic [16:0] H_LIMIT = 17'(HD);

    logic [DW-1:0] wih_mem [WIH_DEPTH];
    logic [DW-1:0] bih_mem [B_DEPTH];
    logic [DW-1:0] whh_mem [WHH_DEPTH];
    logic [DW-1:0] bhh_mem [B_DEPTH];
    logic [DW-1:0] h_mem   [HD];

    logic [DW-1:0] mdata_q, mdata_d;
    logic [DW-1:0] rd_q, rd_d;
    logic [16:0]   wr_count_q;
    logic          err_q;
    logic          core_err, host_err, feed_err;
    logic          h_we, x_we, run_start;
    logic [10:0]   len;

    rnn_input_feeder #(.T_MAX(T_MAX)) u_feeder (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .seq_len_i   (seq_len),
        .busy_i      (busy),
        .i_en_i      (i_en),
        .x_we_i      (x_we),
        .x_addr_i    (ld_addr[HAW-1:0]),
        .x_data_i    (ld_data),
        .ready_o     (ready),
        .done_o      (done),
        .idata_o     (idata),
        .len_o       (len),
        .run_start_o (run_start),
        .feed_err_o  (feed_err)
    );

    // Core-side decode; weight regions wrap on their own size without error.
    always_comb begin
        mdata_d  = mdata_q;
        core_err = 1'b0;
        h_we     = 1'b0;
        if (mce) begin
            case (msel)
                MSEL_WIH: mdata_d = wih_mem[maddr[10:0]];
                MSEL_BIH: mdata_d = bih_mem[maddr[5:0]];
                MSEL_WHH: mdata_d = whh_mem[maddr[11:0]];
                MSEL_BHH: mdata_d = bhh_mem[maddr[5:0]];
                MSEL_LEN: mdata_d = {{(DW-11){1'b0}}, len};
                MSEL_HOUT: begin
                    mdata_d = '0;
                    if (maddr < H_LIMIT) begin
                        h_we = 1'b1;
                    end else begin
                        core_err = 1'b1;
                    end
                end
                default: begin
                    mdata_d  = '0;
                    core_err = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        host_err = 1'b0;
        x_we     = 1'b0;
        if (ld_en && !reset) begin
            case (ld_sel)
                LD_X:                x_we     = 1'b1;
                MSEL_LEN, MSEL_HOUT: host_err = 1'b1;
                default:             ;
            endcase
        end
        rd_d = (rd_addr < H_LIMIT) ? h_mem[rd_addr[HAW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ld_en) begin
                case (ld_sel)
                    MSEL_WIH: wih_mem[ld_addr[10:0]] <= ld_data[DW-1:0];
                    MSEL_BIH: bih_mem[ld_addr[5:0]]  <= ld_data[DW-1:0];
                    MSEL_WHH: whh_mem[ld_addr[11:0]] <= ld_data[DW-1:0];
                    MSEL_BHH: bhh_mem[ld_addr[5:0]]  <= ld_data[DW-1:0];
                    default:  ;
                endcase
            end
            if (h_we) begin
                h_mem[maddr[HAW-1:0]] <= mdata_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdata_q    <= '0;
            rd_q       <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            mdata_q <= mdata_d;
            rd_q    <= rd_d;
            err_q   <= err_q | core_err | host_err | feed_err;
            if (run_start) begin
                wr_count_q <= '0;
            end else if (h_we) begin
                wr_count_q <= wr_count_q + 17'd1;
            end
        end
    end

    assign mdata_r  = mdata_q;
    assign rd_data  = rd_q;
    assign wr_count = wr_count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed bench for rnn_mem_responder with a transaction-level reference
// model compared against the DUT on every negative clock edge.
module tb_rnn_mem_responder;

    logic        clk;
    logic        reset;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic [19:0] mdata_r;
    logic        ready;
    logic        busy;
    logic        i_en;
    logic [31:0] idata;
    logic        start;
    logic [10:0] seq_len;
    logic        ld_en;
    logic [2:0]  ld_sel;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic [16:0] rd_addr;
    logic [19:0] rd_data;
    logic        done;
    logic [16:0] wr_count;
    logic        err;

    rnn_mem_responder #(.T_MAX(32), .DW(20)) dut (
        .clk(clk), .reset(reset), .mce(mce), .msel(msel), .maddr(maddr),
        .mdata_w(mdata_w), .mdata_r(mdata_r), .ready(ready), .busy(busy),
        .i_en(i_en), .idata(idata), .start(start), .seq_len(seq_len),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
        .wr_count(wr_count), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference model: memories as plain arrays, run phase as an integer.
    logic [19:0] m_wih [2048];
    logic [19:0] m_bih [64];
    logic [19:0] m_whh [4096];
    logic [19:0] m_bhh [64];
    logic [19:0] m_h   [2048];
    logic [31:0] m_x   [2048];
    logic [10:0] m_len;
    logic [19:0] e_mdata, e_rd;
    logic [31:0] e_idata;
    logic        e_ready, e_done, e_err;
    int          e_wr, xp, phase;
    bit          live = 0;

    always @(posedge clk) begin : model
        int  a, la;
        bit  hw;
        if (reset) begin
            live = 1; e_mdata = 0; e_rd = 0; e_wr = 0; e_err = 0;
            e_ready = 0; e_done = 0; e_idata = 0; xp = 0; phase = 0;
        end else if (live) begin
            a  = int'(maddr);
            la = int'(ld_addr);
            hw = 0;
            if (mce) begin
                case (msel)
                    3'd0: e_mdata = m_wih[a % 2048];
                    3'd1: e_mdata = m_bih[a % 64];
                    3'd2: e_mdata = m_whh[a % 4096];
                    3'd3: e_mdata = m_bhh[a % 64];
                    3'd4: e_mdata = {9'd0, m_len};
                    3'd5: begin
                        e_mdata = 0;
                        if (a < 2048) hw = 1; else e_err = 1;
                    end
                    default: begin e_mdata = 0; e_err = 1; end
                endcase
            end
            e_rd = (int'(rd_addr) < 2048) ? m_h[int'(rd_addr)] : 'x;
            if (i_en) begin
                if (xp < 32) begin e_idata = m_x[xp]; xp++; end
                else begin e_idata = 0; e_err = 1; end
            end
            if (ld_en) begin
                case (ld_sel)
                    3'd0: m_wih[la % 2048] = ld_data[19:0];
                    3'd1: m_bih[la % 64]   = ld_data[19:0];
                    3'd2: m_whh[la % 4096] = ld_data[19:0];
                    3'd3: m_bhh[la % 64]   = ld_data[19:0];
                    3'd6: m_x[la % 2048]   = ld_data;
                    3'd4, 3'd5: e_err = 1;
                    default: ;
                endcase
            end
            if (hw) begin m_h[a] = mdata_w; e_wr++; end
            case (phase)
                0: if (start) begin
                    phase = 1; e_ready = 1; m_len = seq_len; xp = 0; e_wr = 0;
                end
                1: if (busy) begin phase = 2; e_ready = 0; end
                2: if (!busy) begin phase = 3; e_done = 1; end
                default: begin phase = 0; e_done = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("ready", {31'd0, ready}, {31'd0, e_ready});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("err", {31'd0, err}, {31'd0, e_err});
            check("wr_count", {15'd0, wr_count}, 32'(e_wr));
            if (!$isunknown(e_mdata)) check("mdata_r", {12'd0, mdata_r}, {12'd0, e_mdata});
            if (!$isunknown(e_rd))    check("rd_data", {12'd0, rd_data}, {12'd0, e_rd});
            if (!$isunknown(e_idata)) check("idata", idata, e_idata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_ld(input logic [2:0] s, input logic [11:0] a, input logic [31:0] d);
        ld_en = 1; ld_sel = s; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
    endtask

    task automatic core_rd(input logic [2:0] s, input logic [16:0] a);
        mce = 1; msel = s; maddr = a;
        tick();
        mce = 0;
    endtask

    task automatic core_wr(input logic [16:0] a, input logic [19:0] d);
        mce = 1; msel = 3'd5; maddr = a; mdata_w = d;
        tick();
        mce = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        clk = 0; reset = 1; mce = 0; msel = 0; maddr = 0; mdata_w = 0;
        busy = 0; i_en = 0; start = 0; seq_len = 0; ld_en = 0; ld_sel = 0;
        ld_addr = 0; ld_data = 0; rd_addr = 0;
        tick(); tick();
        reset = 0;
        check("rst_mdata", {12'd0, mdata_r}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_idata", idata, 32'd0);
        check("rst_rd", {12'd0, rd_data}, 32'd0);
        check("rst_wrcnt", {15'd0, wr_count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Weight reads, hold, and region wrap
        host_ld(3'd0, 12'd5, 32'h0000ABCD);
        host_ld(3'd0, 12'd5, 32'h000ABCD);
        core_rd(3'd0, 17'd5);
        check("wih5_read", {12'd0, mdata_r}, 32'h000ABCD);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wih5_hold", {12'd0, mdata_r}, 32'h000ABCD);
        end
        core_rd(3'd0, 17'd2053);
        check("wih_wrap", {12'd0, mdata_r}, 32'h000ABCD);
        host_ld(3'd1, 12'd3, 32'h0001F00F);
        core_rd(3'd1, 17'd67);
        check("bih_wrap", {12'd0, mdata_r}, 32'h1F00F);
        host_ld(3'd2, 12'd4095, 32'h0007FFFF);
        core_rd(3'd2, 17'd8191);
        check("whh_wrap", {12'd0, mdata_r}, 32'h7FFFF);
        host_ld(3'd3, 12'd63, 32'h00080001);
        core_rd(3'd3, 17'd127);
        check("bhh_wrap", {12'd0, mdata_r}, 32'h80001);
        check("wrap_no_err", {31'd0, err}, 32'd0);

        // Same-cycle host write and core read return the old word
        host_ld(3'd0, 12'd6, 32'h00000111);
        ld_en = 1; ld_sel = 3'd0; ld_addr = 12'd6; ld_data = 32'h00000222;
        mce = 1; msel = 3'd0; maddr = 17'd6;
        tick();
        ld_en = 0; mce = 0;
        check("rw_same_old", {12'd0, mdata_r}, 32'h00111);
        core_rd(3'd0, 17'd6);
        check("rw_after_new", {12'd0, mdata_r}, 32'h00222);

        host_ld(3'd6, 12'd0, 32'hDEADBEEF);
        host_ld(3'd6, 12'd1, 32'h00000001);

        // Start a run and complete the handshake
        seq_len = 11'd7; start = 1;
        tick();
        start = 0;
        check("offer_ready", {31'd0, ready}, 32'd1);
        core_rd(3'd4, 17'd0);
        check("len_read", {12'd0, mdata_r}, 32'h00007);
        seq_len = 11'd9; start = 1;
        tick();
        start = 0;
        core_rd(3'd4, 17'd0);
        check("start_ignored", {12'd0, mdata_r}, 32'h00007);
        busy = 1;
        tick();
        check("ready_drop", {31'd0, ready}, 32'd0);

        i_en = 1; tick(); i_en = 0;
        check("idata0", idata, 32'hDEADBEEF);
        tick(); tick(); tick();
        check("idata0_hold", idata, 32'hDEADBEEF);
        i_en = 1; tick(); i_en = 0;
        check("idata1", idata, 32'h00000001);

        core_wr({11'd2, 6'd63}, 20'hF0000);
        check("hwr_mdata0", {12'd0, mdata_r}, 32'd0);
        rd_addr = 17'd191;
        tick();
        check("h191_read", {12'd0, rd_data}, 32'hF0000);
        check("wrcnt_one", {15'd0, wr_count}, 32'd1);

        busy = 0;
        tick();
        check("done_pulse", {31'd0, done}, 32'd1);
        tick();
        check("done_clear", {31'd0, done}, 32'd0);

        // Each error source, isolated by reset
        do_reset();
        check("err_clear", {31'd0, err}, 32'd0);
        core_rd(3'd6, 17'd0);
        check("err_msel110", {31'd0, err}, 32'd1);
        check("msel110_zero", {12'd0, mdata_r}, 32'd0);
        tick(); tick();
        check("err_sticky", {31'd0, err}, 32'd1);

        do_reset();
        core_wr(17'd0, 20'h12121);
        check("h0_wrcnt", {15'd0, wr_count}, 32'd1);
        core_wr(17'd2048, 20'h55555);
        check("err_hrange", {31'd0, err}, 32'd1);
        check("drop_wrcnt", {15'd0, wr_count}, 32'd1);
        rd_addr = 17'd0;
        tick();
        check("h0_intact", {12'd0, rd_data}, 32'h12121);

        do_reset();
        host_ld(3'd5, 12'd0, 32'd0);
        check("err_ldsel", {31'd0, err}, 32'd1);

        do_reset();
        host_ld(3'd6, 12'd31, 32'hA5A5A5A5);
        i_en = 1;
        for (int i = 0; i < 31; i++) tick();
        check("xptr31_no_err", {31'd0, err}, 32'd0);
        tick();
        check("x31_read", idata, 32'hA5A5A5A5);
        check("x31_no_err", {31'd0, err}, 32'd0);
        tick();
        i_en = 0;
        check("xover_zero", idata, 32'd0);
        check("err_xover", {31'd0, err}, 32'd1);

        // Reset in the middle of a run
        do_reset();
        seq_len = 11'd3; start = 1; tick(); start = 0;
        busy = 1; tick();
        reset = 1; tick(); reset = 0;
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        busy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        core_rd(3'd0, 17'd5);
        check("wih5_kept", {12'd0, mdata_r}, 32'h000ABCD);
        seq_len = 11'd5; start = 1; tick(); start = 0;
        check("idle_restart", {31'd0, ready}, 32'd1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
